// File: rtl/inequality.sv
// Unsigned magnitude classifier: compares num against a programmable
// threshold, registers a one-hot result and keeps saturating per-class counts.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous active-high reset
//   num        unsigned operand to classify (sampled when num_valid=1)
//   num_valid  sample strobe for num
//   thr_we     threshold write enable
//   thr_din    new threshold value
//   cnt_clr    synchronous clear of all three counters
//   out        one-hot result {gt, eq, lt}
//   out_valid  high for one cycle after each sample
//   thr        current threshold register
//   cnt_gt     number of num>thr results (saturating)
//   cnt_eq     number of num==thr results (saturating)
//   cnt_lt     number of num<thr results (saturating)

module inequality #(
    parameter int WIDTH     = 4,
    parameter int THR_RESET = 12,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num,
    input  logic             num_valid,
    input  logic             thr_we,
    input  logic [WIDTH-1:0] thr_din,
    input  logic             cnt_clr,
    output logic [2:0]       out,
    output logic             out_valid,
    output logic [WIDTH-1:0] thr,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt
);

    localparam logic [WIDTH-1:0] THR_INIT = WIDTH'(THR_RESET);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic       is_gt;
    logic       is_eq;
    logic       is_lt;
    logic [2:0] cls;

    // Compare against the registered threshold, so a same-edge write
    // only affects later samples.
    always_comb begin
        is_gt = (num > thr);
        is_eq = (num == thr);
        is_lt = (num < thr);
        cls   = {is_gt, is_eq, is_lt};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= 3'b000;
            out_valid <= 1'b0;
            thr       <= THR_INIT;
        end else begin
            out_valid <= num_valid;
            if (num_valid) begin
                out <= cls;
            end
            if (thr_we) begin
                thr <= thr_din;
            end
        end
    end

    // Clear takes priority over a same-edge increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_gt <= '0;
            cnt_eq <= '0;
            cnt_lt <= '0;
        end else if (cnt_clr) begin
            cnt_gt <= '0;
            cnt_eq <= '0;
            cnt_lt <= '0;
        end else if (num_valid) begin
            if (is_gt && cnt_gt != CNT_MAX) begin
                cnt_gt <= cnt_gt + CNT_ONE;
            end
            if (is_eq && cnt_eq != CNT_MAX) begin
                cnt_eq <= cnt_eq + CNT_ONE;
            end
            if (is_lt && cnt_lt != CNT_MAX) begin
                cnt_lt <= cnt_lt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_inequality.sv
// Self-checking bench for inequality: scoreboard of expected results
// pushed at drive time and popped when out_valid is observed.

module tb_inequality;

    localparam int W   = 4;
    localparam int TR  = 12;
    localparam int CW  = 8;
    localparam int CMX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  num;
    logic          num_valid;
    logic          thr_we;
    logic [W-1:0]  thr_din;
    logic          cnt_clr;
    logic [2:0]    out;
    logic          out_valid;
    logic [W-1:0]  thr;
    logic [CW-1:0] cnt_gt;
    logic [CW-1:0] cnt_eq;
    logic [CW-1:0] cnt_lt;

    inequality #(.WIDTH(W), .THR_RESET(TR), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .num(num), .num_valid(num_valid),
        .thr_we(thr_we), .thr_din(thr_din), .cnt_clr(cnt_clr),
        .out(out), .out_valid(out_valid), .thr(thr),
        .cnt_gt(cnt_gt), .cnt_eq(cnt_eq), .cnt_lt(cnt_lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] o;
    } exp_t;

    exp_t       q[$];
    int         m_thr;
    int         m_gt;
    int         m_eq;
    int         m_lt;
    logic [2:0] m_out;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".thr"}, 32'(thr), m_thr);
        chk({tag, ".cnt_gt"}, 32'(cnt_gt), m_gt);
        chk({tag, ".cnt_eq"}, 32'(cnt_eq), m_eq);
        chk({tag, ".cnt_lt"}, 32'(cnt_lt), m_lt);
    endtask

    task automatic model_reset();
        m_thr = TR;
        m_gt  = 0;
        m_eq  = 0;
        m_lt  = 0;
        m_out = 3'b000;
        q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".out"}, 32'(out), 0);
        chk({tag, ".out_valid"}, 32'(out_valid), 0);
        chk_state(tag);
    endtask

    // Called at a negedge; drives one cycle and checks after the posedge.
    task automatic cyc(input int n, input bit v, input bit we,
                       input int din, input bit clr, input string tag);
        exp_t e;
        logic [31:0] nv;
        logic [31:0] dv;
        nv        = n;
        dv        = din;
        num       = nv[W-1:0];
        num_valid = v;
        thr_we    = we;
        thr_din   = dv[W-1:0];
        cnt_clr   = clr;
        if (v) begin
            if (n > m_thr) begin
                m_out = 3'b100;
                if (m_gt < CMX) m_gt++;
            end else if (n == m_thr) begin
                m_out = 3'b010;
                if (m_eq < CMX) m_eq++;
            end else begin
                m_out = 3'b001;
                if (m_lt < CMX) m_lt++;
            end
            e.o = m_out;
            q.push_back(e);
        end
        if (clr) begin
            m_gt = 0;
            m_eq = 0;
            m_lt = 0;
        end
        if (we) m_thr = din;
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            if (q.size() == 0) begin
                chk({tag, ".sb_empty"}, 1, 0);
            end else begin
                e = q.pop_front();
                chk({tag, ".out"}, 32'(out), 32'(e.o));
            end
        end else begin
            chk({tag, ".out_hold"}, 32'(out), 32'(m_out));
        end
        chk_state(tag);
        @(negedge clk);
        num_valid = 1'b0;
        thr_we    = 1'b0;
        cnt_clr   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        num       = '0;
        num_valid = 1'b0;
        thr_we    = 1'b0;
        thr_din   = '0;
        cnt_clr   = 1'b0;
        model_reset();
        #12;
        chk_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Equal to reset threshold
        cyc(12, 1, 0, 0, 0, "eq12");
        cyc(0, 0, 0, 0, 0, "idle");

        // Greater, then less
        do_reset();
        cyc(13, 1, 0, 0, 0, "gt13");
        cyc(3, 1, 0, 0, 0, "lt3");

        // Same-edge threshold write uses old threshold
        cyc(12, 1, 1, 5, 0, "wr_eq");
        cyc(5, 1, 0, 0, 0, "new_thr");

        // Saturation then clear with a same-edge sample
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(12, 1, 0, 0, 0, "sat");
        end
        cyc(12, 1, 0, 0, 1, "clr");

        // Threshold boundaries
        cyc(0, 0, 1, 15, 0, "thr15");
        cyc(15, 1, 0, 0, 0, "max_eq");
        cyc(0, 1, 0, 0, 0, "max_lt");
        cyc(0, 0, 1, 0, 0, "thr0");
        cyc(0, 1, 0, 0, 0, "zero_eq");
        cyc(1, 1, 0, 0, 0, "zero_gt");
        cyc(15, 1, 0, 0, 0, "zero_gt2");

        // Mixed random traffic
        for (int i = 0; i < 40; i++) begin
            cyc(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 15)),
                1'($urandom_range(0, 15) == 0), "rnd");
        end

        // Asynchronous reset between edges, sample in flight
        cyc(3, 1, 1, 9, 0, "pre_rst");
        num       = 4'd14;
        num_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_reset("async");
        // Inputs ignored while reset is held
        thr_we  = 1'b1;
        thr_din = 4'd2;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        chk_reset("held");
        @(negedge clk);
        num_valid = 1'b0;
        thr_we    = 1'b0;
        rst       = 1'b0;
        cyc(0, 0, 0, 0, 0, "post_rst");
        cyc(12, 1, 0, 0, 0, "post_eq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
